// File: rtl/sliding_window.sv
// Sliding-window generator: turns a padded, channel-interleaved pixel stream into
// KERNEL_HEIGHT x KERNEL_WIDTH windows, one per output position per channel.
// The most recent KERNEL_HEIGHT rows live in a register line buffer; the newest
// element of each window is bypassed straight from data_in.
module sliding_window #(
    parameter int DATA_WIDTH    = 32,
    parameter int IMG_WIDTH     = 8,
    parameter int IMG_HEIGHT    = 7,
    parameter int CHANNELS      = 2,
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int STRIDE        = 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [DATA_WIDTH-1:0]                           data_in,
    input  logic                                            data_in_valid,
    output logic                                            data_in_ready,
    output logic [KERNEL_HEIGHT*KERNEL_WIDTH*DATA_WIDTH-1:0] data_out,
    output logic                                            data_out_valid,
    input  logic                                            data_out_ready
);

    localparam int WIN_W = KERNEL_HEIGHT * KERNEL_WIDTH * DATA_WIDTH;
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int XW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int RW    = (KERNEL_HEIGHT > 1) ? $clog2(KERNEL_HEIGHT) : 1;
    localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0] C_LAST  = CW'(CHANNELS - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] R_LAST  = RW'(KERNEL_HEIGHT - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(STRIDE - 1);
    localparam logic [XW-1:0] X_FIRST = XW'(KERNEL_WIDTH - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(KERNEL_HEIGHT - 1);

    // Row slot count_y % KERNEL_HEIGHT, kept as a wrap counter alongside count_y.
    logic [CW-1:0] count_c_q, count_c_d;
    logic [XW-1:0] count_x_q, count_x_d;
    logic [YW-1:0] count_y_q, count_y_d;
    logic [RW-1:0] row_q, row_d;
    logic [SW-1:0] phase_x_q, phase_x_d;
    logic [SW-1:0] phase_y_q, phase_y_d;
    logic          data_out_valid_q, data_out_valid_d;
    logic [WIN_W-1:0] data_out_q, data_out_d;
    logic [WIN_W-1:0] window;

    logic [DATA_WIDTH-1:0] line_buf [KERNEL_HEIGHT][IMG_WIDTH][CHANNELS];

    logic accept;
    logic emit;

    assign data_in_ready  = !data_out_valid_q || data_out_ready;
    assign accept         = data_in_valid && data_in_ready;
    assign emit           = accept && (count_x_q >= X_FIRST) && (count_y_q >= Y_FIRST) &&
                            (phase_x_q == '0) && (phase_y_q == '0);
    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;

    // Window taps: row slot for ky is (row_q + 1 + ky) mod KERNEL_HEIGHT, oldest row first.
    for (genvar ky = 0; ky < KERNEL_HEIGHT; ky++) begin : g_row
        logic [RW:0]   row_sum;
        logic [RW-1:0] row_sel;
        assign row_sum = {1'b0, row_q} + (RW+1)'(ky + 1);
        assign row_sel = (row_sum > {1'b0, R_LAST}) ?
                         RW'(row_sum - (RW+1)'(KERNEL_HEIGHT)) : RW'(row_sum);
        for (genvar kx = 0; kx < KERNEL_WIDTH; kx++) begin : g_col
            if (ky == KERNEL_HEIGHT - 1 && kx == KERNEL_WIDTH - 1) begin : g_bypass
                assign window[(ky*KERNEL_WIDTH+kx)*DATA_WIDTH +: DATA_WIDTH] = data_in;
            end else begin : g_tap
                logic [XW-1:0] col;
                assign col = count_x_q - XW'(KERNEL_WIDTH - 1 - kx);
                assign window[(ky*KERNEL_WIDTH+kx)*DATA_WIDTH +: DATA_WIDTH] =
                    line_buf[row_sel][col][count_c_q];
            end
        end
    end

    // Next-state: stream position counters, stride phases and output register.
    always_comb begin
        count_c_d        = count_c_q;
        count_x_d        = count_x_q;
        count_y_d        = count_y_q;
        row_d            = row_q;
        phase_x_d        = phase_x_q;
        phase_y_d        = phase_y_q;
        data_out_valid_d = data_out_valid_q;
        data_out_d       = data_out_q;

        if (accept) begin
            if (count_c_q != C_LAST) begin
                count_c_d = count_c_q + 1'b1;
            end else begin
                count_c_d = '0;
                if (count_x_q != X_LAST) begin
                    count_x_d = count_x_q + 1'b1;
                    // Phase stays 0 until the first window column, then wraps every STRIDE.
                    if (count_x_q < X_FIRST || phase_x_q == S_LAST) phase_x_d = '0;
                    else                                         phase_x_d = phase_x_q + 1'b1;
                end else begin
                    count_x_d = '0;
                    phase_x_d = '0;
                    if (count_y_q != Y_LAST) begin
                        count_y_d = count_y_q + 1'b1;
                        row_d     = (row_q == R_LAST) ? '0 : row_q + 1'b1;
                        if (count_y_q < Y_FIRST || phase_y_q == S_LAST) phase_y_d = '0;
                        else                                         phase_y_d = phase_y_q + 1'b1;
                    end else begin
                        count_y_d = '0;
                        row_d     = '0;
                        phase_y_d = '0;
                    end
                end
            end
        end

        if (emit) begin
            data_out_valid_d = 1'b1;
            data_out_d       = window;
        end else if (data_out_ready) begin
            data_out_valid_d = 1'b0;
        end
    end

    // Control and output state, asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_c_q        <= '0;
            count_x_q        <= '0;
            count_y_q        <= '0;
            row_q            <= '0;
            phase_x_q        <= '0;
            phase_y_q        <= '0;
            data_out_valid_q <= 1'b0;
            data_out_q       <= '0;
        end else begin
            count_c_q        <= count_c_d;
            count_x_q        <= count_x_d;
            count_y_q        <= count_y_d;
            row_q            <= row_d;
            phase_x_q        <= phase_x_d;
            phase_y_q        <= phase_y_d;
            data_out_valid_q <= data_out_valid_d;
            data_out_q       <= data_out_d;
        end
    end

    // Line buffer write; unreset because only rows of the current frame are ever read.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf[row_q][count_x_q][count_c_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_sliding_window.sv
// Testbench for sliding_window: directed frames compared against a window model,
// a table of hand-computed windows, and multi-cycle stall / reset / stride sequences.
module tb_sliding_window;

    localparam int DW = 32;
    localparam int WW = 9 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_in_valid = 1'b0;
    logic          data_in_ready;
    logic [WW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready = 1'b1;

    logic          s2_valid = 1'b0;
    logic          s2_ready;
    logic [WW-1:0] s2_out;
    logic          s2_out_valid;

    sliding_window dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    sliding_window #(.STRIDE(2)) dut_s2 (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (s2_valid),
        .data_in_ready  (s2_ready),
        .data_out       (s2_out),
        .data_out_valid (s2_out_valid),
        .data_out_ready (1'b1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int e[9];
    } vec_t;

    vec_t          tbl[5];
    logic [WW-1:0] cap[$];
    logic [WW-1:0] cap2[$];
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] exp2_q[$];
    int            n_pass = 0;
    int            n_total = 0;
    int            rdy_mode = 0;

    // Record every window handshake; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst && data_out_valid && data_out_ready) cap.push_back(data_out);
        if (rst && s2_out_valid) cap2.push_back(s2_out);
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) data_out_ready = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int pix(input int off, input int x, input int y, input int c);
        return off + (y * 8 + x) * 2 + c;
    endfunction

    task automatic add_frame(input int off, input int s, input bit to2);
        logic [WW-1:0] w;
        for (int y = 2; y < 7; y += s)
            for (int x = 2; x < 8; x += s)
                for (int c = 0; c < 2; c++) begin
                    w = '0;
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            w[(ky*3+kx)*DW +: DW] = DW'(pix(off, x - 2 + kx, y - 2 + ky, c));
                    if (to2) exp2_q.push_back(w);
                    else     exp_q.push_back(w);
                end
    endtask

    task automatic compare_stream(input string name);
        int n;
        check({name, "_count"}, WW'(cap.size()), WW'(exp_q.size()));
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_win%0d", name, i), cap[i], exp_q[i]);
        cap.delete();
        exp_q.delete();
    endtask

    task automatic send_elem(input int v, input int gap_max);
        bit done = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
        end
        data_in       = DW'(v);
        data_in_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (data_in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        data_in_valid = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL accept_timeout: element %0d not accepted, expected within 200 cycles", v);
        end
    endtask

    task automatic send_frame(input int off, input int gap_max);
        for (int i = 0; i < 112; i++) send_elem(off + i, gap_max);
    endtask

    task automatic drain();
        rdy_mode       = 0;
        data_out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        data_in_valid = 1'b0;
        s2_valid      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cap.delete();
        cap2.delete();
        exp_q.delete();
        exp2_q.delete();
    endtask

    function automatic logic [WW-1:0] tbl_win(input int k);
        logic [WW-1:0] w = '0;
        for (int j = 0; j < 9; j++) w[j*DW +: DW] = DW'(tbl[k].e[j]);
        return w;
    endfunction

    initial begin
        logic [WW-1:0] snap;

        tbl[0].idx = 0;  tbl[0].e = '{0, 2, 4, 16, 18, 20, 32, 34, 36};
        tbl[1].idx = 1;  tbl[1].e = '{1, 3, 5, 17, 19, 21, 33, 35, 37};
        tbl[2].idx = 2;  tbl[2].e = '{2, 4, 6, 18, 20, 22, 34, 36, 38};
        tbl[3].idx = 12; tbl[3].e = '{16, 18, 20, 32, 34, 36, 48, 50, 52};
        tbl[4].idx = 59; tbl[4].e = '{75, 77, 79, 91, 93, 95, 107, 109, 111};

        // Reset state
        do_reset();
        check("reset_valid", WW'(data_out_valid), WW'(0));
        check("reset_data", data_out, '0);
        check("reset_in_ready", WW'(data_in_ready), WW'(1));

        // Full frame, ready held high; first window appears after element 36
        for (int i = 0; i < 112; i++) begin
            send_elem(i, 0);
            if (i == 35) check("latency_before", WW'(data_out_valid), WW'(0));
            if (i == 36) begin
                check("latency_first", WW'(data_out_valid), WW'(1));
                check("latency_first_data", data_out, tbl_win(0));
            end
        end
        drain();
        for (int k = 0; k < 5; k++) begin
            if (tbl[k].idx < cap.size()) check($sformatf("table_%0d", tbl[k].idx),
                                               cap[tbl[k].idx], tbl_win(k));
            else check($sformatf("table_%0d_missing", tbl[k].idx), WW'(cap.size()),
                       WW'(tbl[k].idx + 1));
        end
        add_frame(0, 1, 1'b0);
        compare_stream("frame");

        // Stride 2 instance: 18 windows per frame
        do_reset();
        for (int i = 0; i < 112; i++) begin
            data_in  = DW'(i);
            s2_valid = 1'b1;
            @(negedge clk);
            check("s2_ready", WW'(s2_ready), WW'(1));
            @(posedge clk);
            #1;
        end
        s2_valid = 1'b0;
        drain();
        add_frame(0, 2, 1'b1);
        check("s2_count", WW'(cap2.size()), WW'(18));
        if (cap2.size() > 0) check("s2_first", cap2[0], tbl_win(0));
        for (int i = 0; i < cap2.size() && i < exp2_q.size(); i++)
            check($sformatf("s2_win%0d", i), cap2[i], exp2_q[i]);

        // Output stall for 5 cycles while a window is pending
        do_reset();
        for (int i = 0; i <= 36; i++) send_elem(i, 0);
        snap           = data_out;
        data_out_ready = 1'b0;
        data_in        = DW'(37);
        data_in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_data", data_out, snap);
            check("stall_valid", WW'(data_out_valid), WW'(1));
            check("stall_in_ready", WW'(data_in_ready), WW'(0));
            @(posedge clk);
            #1;
        end
        data_out_ready = 1'b1;
        for (int i = 37; i < 112; i++) send_elem(i, 0);
        drain();
        add_frame(0, 1, 1'b0);
        compare_stream("stall");

        // Two back-to-back frames, second offset by 1000
        do_reset();
        send_frame(0, 0);
        send_frame(1000, 0);
        drain();
        add_frame(0, 1, 1'b0);
        add_frame(1000, 1, 1'b0);
        compare_stream("b2b");

        // Mid-frame reset while a window is valid, then a clean frame
        do_reset();
        for (int i = 0; i <= 47; i++) send_elem(i, 0);
        check("pre_reset_valid", WW'(data_out_valid), WW'(1));
        rst = 1'b0;
        #1;
        check("midreset_valid", WW'(data_out_valid), WW'(0));
        check("midreset_data", data_out, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cap.delete();
        send_frame(0, 0);
        drain();
        add_frame(0, 1, 1'b0);
        compare_stream("restart");

        // Random valid gaps and ready toggling over three frames
        do_reset();
        rdy_mode = 1;
        send_frame(0, 2);
        send_frame(1000, 2);
        send_frame(2000, 2);
        drain();
        add_frame(0, 1, 1'b0);
        add_frame(1000, 1, 1'b0);
        add_frame(2000, 1, 1'b0);
        compare_stream("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
